// File: rtl/vga_pixel_scanner.sv
// VGA raster scanner: free-running pixel/line counters, a two-stage timing
// pipeline that lines up sync and blank with the colour returned by the object mux.
module vga_pixel_scanner #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  RGBin,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic        hSyncN,
  output logic        vSyncN,
  output logic        blankN,
  output logic [3:0]  vgaR,
  output logic [3:0]  vgaG,
  output logic [3:0]  vgaB
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic h_wrap, v_wrap;
  logic active, hs, vs;
  logic active_d1, hs_d1, vs_d1;
  logic [3:0] r_exp, g_exp, b_exp;

  assign h_wrap = (pixelX == H_LAST);
  assign v_wrap = (pixelY == V_LAST);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixelX       <= '0;
      pixelY       <= '0;
      startOfFrame <= 1'b0;
    end else begin
      pixelX <= h_wrap ? '0 : pixelX + 11'd1;
      if (h_wrap) pixelY <= v_wrap ? '0 : pixelY + 11'd1;
      // Only a true frame wrap raises the pulse, never the (0,0) left by reset.
      startOfFrame <= h_wrap && v_wrap;
    end
  end

  assign active = (pixelX < H_VIS) && (pixelY < V_VIS);
  assign hs     = (pixelX >= HS_FIRST) && (pixelX <= HS_LAST);
  assign vs     = (pixelY >= VS_FIRST) && (pixelY <= VS_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      active_d1 <= 1'b0;
      hs_d1     <= 1'b0;
      vs_d1     <= 1'b0;
    end else begin
      active_d1 <= active;
      hs_d1     <= hs;
      vs_d1     <= vs;
    end
  end

  // NOTE: defaults first so the blanked branch cannot infer a latch.
  always_comb begin
    r_exp = '0;
    g_exp = '0;
    b_exp = '0;
    if (active_d1) begin
      r_exp = {RGBin[7:5], RGBin[7]};
      g_exp = {RGBin[4:2], RGBin[4]};
      b_exp = {RGBin[1:0], RGBin[1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hSyncN <= 1'b1;
      vSyncN <= 1'b1;
      blankN <= 1'b0;
      vgaR   <= '0;
      vgaG   <= '0;
      vgaB   <= '0;
    end else begin
      hSyncN <= ~hs_d1;
      vSyncN <= ~vs_d1;
      blankN <= active_d1;
      vgaR   <= r_exp;
      vgaG   <= g_exp;
      vgaB   <= b_exp;
    end
  end

endmodule

// File: tb/tb_vga_pixel_scanner.sv
// Scoreboard bench for vga_pixel_scanner on a shrunken raster so several frames,
// mid-frame resets and random colours fit in a short run.
module tb_vga_pixel_scanner;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int N_CYCLES = 6 * FRAME;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  RGBin;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, hSyncN, vSyncN, blankN;
  logic [3:0]  vgaR, vgaG, vgaB;

  vga_pixel_scanner #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .reset(reset), .RGBin(RGBin),
    .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
    .hSyncN(hSyncN), .vSyncN(vSyncN), .blankN(blankN),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, sof, hsn, vsn, bn, r, g, b;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: s = cycles since the last reset edge; the raster position is
  // s mod FRAME and colour outputs show the pixel from two cycles earlier.
  function automatic exp_t model(input int s, input logic [7:0] rgb);
    exp_t e;
    int p, px, py, rv, gv, bv;
    p     = s % FRAME;
    e.x   = p % HT;
    e.y   = p / HT;
    e.sof = (s > 0 && p == 0) ? 1 : 0;
    e.hsn = 1; e.vsn = 1; e.bn = 0; e.r = 0; e.g = 0; e.b = 0;
    if (s >= 2) begin
      p  = (s - 2) % FRAME;
      px = p % HT;
      py = p / HT;
      e.hsn = (px >= HA + HFP && px < HA + HFP + HS) ? 0 : 1;
      e.vsn = (py >= VA + VFP && py < VA + VFP + VS) ? 0 : 1;
      if (px < HA && py < VA) begin
        rv = int'(rgb) / 32;
        gv = (int'(rgb) / 4) % 8;
        bv = int'(rgb) % 4;
        e.bn = 1;
        e.r  = (rv * 30 + 7) / 14;  // nearest 4-bit level of a 3-bit channel
        e.g  = (gv * 30 + 7) / 14;
        e.b  = bv * 5;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("pixelX",       int'(pixelX),       e.x);
      check("pixelY",       int'(pixelY),       e.y);
      check("startOfFrame", int'(startOfFrame), e.sof);
      check("hSyncN",       int'(hSyncN),       e.hsn);
      check("vSyncN",       int'(vSyncN),       e.vsn);
      check("blankN",       int'(blankN),       e.bn);
      check("vgaR",         int'(vgaR),         e.r);
      check("vgaG",         int'(vgaG),         e.g);
      check("vgaB",         int'(vgaB),         e.b);
    end
  end

  initial begin
    logic [7:0] specials [4];
    logic [7:0] rgb_prev, rgb_next;
    bit   rst_prev, rst_next, mid_done;
    int   s, rst_hold;

    specials[0] = 8'hFF;
    specials[1] = 8'b101_011_10;
    specials[2] = 8'hE0;
    specials[3] = 8'h00;
    reset    = 1'b1;
    RGBin    = 8'h00;
    rst_prev = 1'b1;
    rgb_prev = 8'h00;
    mid_done = 1'b0;
    s        = 0;
    rst_hold = 0;

    for (int c = 0; c < N_CYCLES; c++) begin
      @(posedge clk);
      #1;
      s = rst_prev ? 0 : s + 1;
      q.push_back(model(s, rgb_prev));

      rst_next = 1'b0;
      if (c < 2) rst_next = 1'b1;
      if (!mid_done && s > FRAME && (s % FRAME) == 5 * HT + 10) begin
        rst_hold = 1;
        mid_done = 1'b1;
      end else if (c > 3 * FRAME && rst_hold == 0 && $urandom_range(0, 249) == 0) begin
        rst_hold = $urandom_range(1, 3);
      end
      if (rst_hold > 0) begin
        rst_next = 1'b1;
        rst_hold--;
      end

      if (c % 4 == 0) rgb_next = specials[(c / 4) % 4];
      else            rgb_next = 8'($urandom);

      reset    = rst_next;
      RGBin    = rgb_next;
      rst_prev = rst_next;
      rgb_prev = rgb_next;
    end

    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pixel_scanner.md
VGA_PIXEL_SCANNER -- requirements
Module: vga_pixel_scanner

Interface
REQ-001 The block SHALL expose parameters (name, default, meaning): H_ACTIVE 640 visible pixels per line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33.
REQ-002 The block SHALL derive H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-003 clk  in  1  pixel clock; one pixel per cycle.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 RGBin  in  8  color from the object mux, 3-3-2 (R[7:5], G[4:2], B[1:0]), valid one cycle after the pixelX/pixelY it answers.
REQ-006 pixelX  out  11  current horizontal count, 0..H_TOTAL-1.
REQ-007 pixelY  out  11  current vertical count, 0..V_TOTAL-1.
REQ-008 startOfFrame  out  1  one-cycle pulse while pixelX=0 and pixelY=0.
REQ-009 hSyncN / vSyncN  out  1 each  active-low sync, pipeline-aligned with color outputs.
REQ-010 blankN  out  1  high when the output pixel is visible.
REQ-011 vgaR / vgaG / vgaB  out  4 each  DAC color outputs.

Function
REQ-012 The pixelX counter SHALL increment every clk and wrap from H_TOTAL-1 to 0.
REQ-013 The pixelY counter SHALL increment only on the cycle pixelX wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-014 pixelX and pixelY SHALL be driven directly from registers, with no combinational path from any input.
REQ-015 Per-count decode: active = (pixelX<H_ACTIVE) and (pixelY<V_ACTIVE); hs = pixelX in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751); vs = pixelY in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491).
REQ-016 Stage 1 SHALL register active, hs and vs from the counters each cycle, aligning them with RGBin.
REQ-017 Stage 2 SHALL register the outputs each cycle:
  - hSyncN = not hs_d1; vSyncN = not vs_d1; blankN = active_d1.
  - vgaR = {RGBin[7:5], RGBin[7]}; vgaG = {RGBin[4:2], RGBin[4]}; vgaB = {RGBin[1:0], RGBin[1:0]}, when active_d1 = 1.
  - vgaR/G/B = 0 when active_d1 = 0.
REQ-018 Total latency SHALL be exactly 2 cycles: outputs at cycle n+2 correspond to pixelX/pixelY at cycle n.
REQ-019 RGBin = 8'hFF (transparent code) SHALL be displayed as white; transparency resolution is upstream.
REQ-020 startOfFrame SHALL be registered and asserted exactly for the cycle in which the counters show (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
REQ-021 startOfFrame SHALL NOT assert on the first (0,0) following reset.
REQ-022 Simultaneous horizontal and vertical wrap SHALL produce (0,0) in one step, with no intermediate (0, V_TOTAL) value.
REQ-023 Parameters SHALL be elaboration-time constants; all comparisons SHALL be 11-bit unsigned.

Reset
REQ-024 While reset = 1 at a clk edge, the block SHALL drive: pixelX = 0, pixelY = 0, startOfFrame = 0, hSyncN = 1, vSyncN = 1, blankN = 0, vgaR/G/B = 0, all pipeline registers cleared.
REQ-025 Reset asserted mid-line or mid-frame SHALL take effect at the next edge and discard in-flight pipeline contents.
REQ-026 After reset deasserts, counting SHALL resume from (0,0) on the next edge; outputs SHALL reflect pixel (0,0) two cycles later.

Verification
REQ-027 Reset for 3 cycles, release -> pixelX = 0,1,2…; blankN goes high at cycle 2 after release; hSyncN = 1, vSyncN = 1.
REQ-028 Run one line -> pixelX wraps 799 to 0 and pixelY increments by 1; hSyncN is low for exactly 96 cycles, starting 2 cycles after pixelX = 656.
REQ-029 Run a full frame of 420000 cycles -> startOfFrame pulses once, when counters hit (0,0) after (799,524); vSyncN is low for 1600 cycles (pixelY 490..491, delayed 2); no pulse at the initial post-reset (0,0).
REQ-030 Drive RGBin = 8'b101_011_10 one cycle after pixelX = 5, pixelY = 0 -> 2 cycles after that pixelX, vgaR = 4'b1011, vgaG = 4'b0110, vgaB = 4'b1010, blankN = 1.
REQ-031 Drive RGBin = 8'hE0 while pixelX ≥ 640 -> vgaR/G/B = 0 and blankN = 0.
REQ-032 Assert reset at pixelX = 300, pixelY = 200 -> next edge all outputs take their reset values; after release, counting restarts at (0,0) with no startOfFrame pulse.
